prbs_checker: RTL and testbench



---
 rtl/gdsp_pkg.sv | 18 +
 rtl/prbs_chk_core.sv | 37 +++
 rtl/prbs_checker.sv | 155 +++++++++++++++
 tb/tb_prbs_checker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gdsp_pkg.sv
// Shared constants and types for the PRBS-23 generator/checker pair.
// The PRBS-23 polynomial is x^23 + x^18 + 1.
package gdsp_pkg;

    localparam int unsigned LFSR_WIDTH     = 23;
    localparam int unsigned LFSR_TAP_A     = 23;
    localparam int unsigned LFSR_TAP_B     = 18;
    localparam int unsigned BITS_PER_SYM   = 4;
    localparam int unsigned PRBS_SEED_SYMS = 6;
    localparam int unsigned POP_WIDTH      = 3;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_chk_state_t;

endpackage

// File: rtl/prbs_chk_core.sv
// Combinational PRBS-23 step unrolled over one symbol.
// Produces the next history, the per-bit errors and the error popcount.
module prbs_chk_core
    import gdsp_pkg::*;
(
    input  logic [LFSR_WIDTH-1:0]   i_hist,
    input  logic [BITS_PER_SYM-1:0] i_bits,
    input  logic                    i_sel_pred,
    output logic [LFSR_WIDTH-1:0]   o_hist_nxt,
    output logic [BITS_PER_SYM-1:0] o_err,
    output logic [POP_WIDTH-1:0]    o_pop
);

    logic [LFSR_WIDTH-1:0]   w_h;
    logic                    w_p;
    logic [BITS_PER_SYM-1:0] w_e;
    logic [POP_WIDTH-1:0]    w_pop;

    // bits_in[3] is earliest in time, so walk the symbol MSB first
    always_comb begin
        w_h   = i_hist;
        w_p   = 1'b0;
        w_e   = '0;
        w_pop = '0;
        for (int i = BITS_PER_SYM - 1; i >= 0; i--) begin
            w_p    = w_h[LFSR_TAP_A-1] ^ w_h[LFSR_TAP_B-1];
            w_e[i] = i_bits[i] ^ w_p;
            w_pop  = w_pop + POP_WIDTH'(w_e[i]);
            w_h    = {w_h[LFSR_WIDTH-2:0], (i_sel_pred ? w_p : i_bits[i])};
        end
    end

    assign o_hist_nxt = w_h;
    assign o_err      = w_e;
    assign o_pop      = w_pop;

endmodule

// File: rtl/prbs_checker.sv
// PRBS-23 receive checker: self-synchronises, locks, and accumulates
// saturating bit/error counts for BER measurement while locked.
module prbs_checker
    import gdsp_pkg::*;
#(
    parameter int unsigned LOCK_SYMS       = 16,
    parameter int unsigned WINDOW_SYMS     = 64,
    parameter int unsigned LOSS_ERR_THRESH = 8,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic [BITS_PER_SYM-1:0] bits_in,
    input  logic                    valid_in,
    output logic                    locked,
    output logic [BITS_PER_SYM-1:0] err_flags,
    output logic                    err_valid,
    output logic [CNT_WIDTH-1:0]    bit_cnt,
    output logic [CNT_WIDTH-1:0]    err_cnt,
    output logic [15:0]             loss_cnt
);

    localparam int unsigned SYM_CW  = 16;
    localparam int unsigned SEED_CW = 3;

    prbs_chk_state_t         r_state;
    logic                    r_locked;
    logic [LFSR_WIDTH-1:0]   r_hist;
    logic [SEED_CW-1:0]      r_seed_cnt;
    logic [SYM_CW-1:0]       r_clean_cnt;
    logic [SYM_CW-1:0]       r_win_cnt;
    logic [SYM_CW-1:0]       r_win_err;
    logic [BITS_PER_SYM-1:0] r_err_flags;
    logic                    r_err_valid;
    logic [CNT_WIDTH-1:0]    r_bit_cnt;
    logic [CNT_WIDTH-1:0]    r_err_cnt;
    logic [15:0]             r_loss_cnt;

    logic [LFSR_WIDTH-1:0]   w_hist_nxt;
    logic [BITS_PER_SYM-1:0] w_err;
    logic [POP_WIDTH-1:0]    w_pop;
    logic                    w_sel_pred;
    logic [CNT_WIDTH:0]      w_bit_sum;
    logic [CNT_WIDTH:0]      w_err_sum;
    logic [CNT_WIDTH-1:0]    w_bit_sat;
    logic [CNT_WIDTH-1:0]    w_err_sat;
    logic [15:0]             w_loss_sat;
    logic [SYM_CW-1:0]       w_win_err_sum;

    // Locked: shift predicted bits so a channel error is not fed back
    assign w_sel_pred = (r_state == LOCKED);

    prbs_chk_core u_core (
        .i_hist     (r_hist),
        .i_bits     (bits_in),
        .i_sel_pred (w_sel_pred),
        .o_hist_nxt (w_hist_nxt),
        .o_err      (w_err),
        .o_pop      (w_pop)
    );

    // Saturating counter increments: carry-out clamps to all-ones
    assign w_bit_sum     = {1'b0, r_bit_cnt} + (CNT_WIDTH+1)'(BITS_PER_SYM);
    assign w_err_sum     = {1'b0, r_err_cnt} + (CNT_WIDTH+1)'(w_pop);
    assign w_bit_sat     = w_bit_sum[CNT_WIDTH] ? '1 : w_bit_sum[CNT_WIDTH-1:0];
    assign w_err_sat     = w_err_sum[CNT_WIDTH] ? '1 : w_err_sum[CNT_WIDTH-1:0];
    assign w_loss_sat    = (r_loss_cnt == '1) ? r_loss_cnt : r_loss_cnt + 16'd1;
    assign w_win_err_sum = r_win_err + SYM_CW'(w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= SEED;
            r_locked    <= 1'b0;
            r_hist      <= '0;
            r_seed_cnt  <= '0;
            r_clean_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_err_flags <= '0;
            r_err_valid <= 1'b0;
            r_bit_cnt   <= '0;
            r_err_cnt   <= '0;
            r_loss_cnt  <= '0;
        end else begin
            r_err_valid <= 1'b0;
            if (valid_in) begin
                r_hist <= w_hist_nxt;
                case (r_state)
                    SEED: begin
                        if (r_seed_cnt == SEED_CW'(PRBS_SEED_SYMS - 1)) begin
                            r_seed_cnt <= '0;
                            // An all-zero history is a degenerate fixed point
                            if (w_hist_nxt != '0) begin
                                r_state     <= VERIFY;
                                r_clean_cnt <= '0;
                            end
                        end else begin
                            r_seed_cnt <= r_seed_cnt + SEED_CW'(1);
                        end
                    end
                    VERIFY: begin
                        if (|w_err) begin
                            r_state    <= SEED;
                            r_seed_cnt <= '0;
                        end else if (r_clean_cnt == SYM_CW'(LOCK_SYMS - 1)) begin
                            r_state   <= LOCKED;
                            r_locked  <= 1'b1;
                            r_win_cnt <= '0;
                            r_win_err <= '0;
                        end else begin
                            r_clean_cnt <= r_clean_cnt + SYM_CW'(1);
                        end
                    end
                    LOCKED: begin
                        r_err_flags <= w_err;
                        r_err_valid <= 1'b1;
                        r_bit_cnt   <= w_bit_sat;
                        r_err_cnt   <= w_err_sat;
                        if (w_win_err_sum >= SYM_CW'(LOSS_ERR_THRESH)) begin
                            r_state    <= SEED;
                            r_locked   <= 1'b0;
                            r_seed_cnt <= '0;
                            r_loss_cnt <= w_loss_sat;
                        end else if (r_win_cnt == SYM_CW'(WINDOW_SYMS - 1)) begin
                            r_win_cnt <= '0;
                            r_win_err <= '0;
                        end else begin
                            r_win_cnt <= r_win_cnt + SYM_CW'(1);
                            r_win_err <= w_win_err_sum;
                        end
                    end
                    default: begin
                        r_state  <= SEED;
                        r_locked <= 1'b0;
                    end
                endcase
            end
            // Clear wins over this cycle's count contribution
            if (clr) begin
                r_bit_cnt  <= '0;
                r_err_cnt  <= '0;
                r_loss_cnt <= '0;
            end
        end
    end

    assign locked    = r_locked;
    assign err_flags = r_err_flags;
    assign err_valid = r_err_valid;
    assign bit_cnt   = r_bit_cnt;
    assign err_cnt   = r_err_cnt;
    assign loss_cnt  = r_loss_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: PRBS-23 source model, error injection table,
// scoreboard of expected err_flags, plus a CNT_WIDTH=8 saturation instance.
module tb_prbs_checker;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [3:0]  bits_in;
    logic        valid_in;

    logic        locked,  locked8;
    logic [3:0]  err_flags, err_flags8;
    logic        err_valid, err_valid8;
    logic [31:0] bit_cnt, err_cnt;
    logic [7:0]  bit_cnt8, err_cnt8;
    logic [15:0] loss_cnt, loss_cnt8;

    prbs_checker dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bits_in(bits_in), .valid_in(valid_in),
        .locked(locked), .err_flags(err_flags), .err_valid(err_valid),
        .bit_cnt(bit_cnt), .err_cnt(err_cnt), .loss_cnt(loss_cnt)
    );

    prbs_checker #(.CNT_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bits_in(bits_in), .valid_in(valid_in),
        .locked(locked8), .err_flags(err_flags8), .err_valid(err_valid8),
        .bit_cnt(bit_cnt8), .err_cnt(err_cnt8), .loss_cnt(loss_cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_tot  = 0;
    logic [22:0] gen;
    logic [3:0]  sb_q[$];

    typedef struct {
        logic        v;
        logic        c;
        logic [3:0]  flip;
        logic        chk;
        logic        exp_lk;
        int unsigned exp_bit;
        int unsigned exp_err;
        int unsigned exp_loss;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        else
            n_pass++;
    endtask

    // Source emits the oldest history bit; recurrence b[n] = b[n-23] ^ b[n-18]
    function automatic logic [3:0] next_sym();
        logic [3:0] s;
        s = '0;
        for (int i = 3; i >= 0; i--) begin
            s[i] = gen[22];
            gen  = {gen[21:0], gen[22] ^ gen[17]};
        end
        return s;
    endfunction

    // One clock of stimulus; chk marks a symbol expected to be processed in LOCKED
    task automatic send(input logic v, input logic [3:0] flip, input logic c, input logic chk);
        logic [3:0] exp_f;
        bits_in  = v ? (next_sym() ^ flip) : 4'h0;
        valid_in = v;
        clr      = c;
        if (v && chk) sb_q.push_back(flip);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        clr      = 1'b0;
        check("err_valid", 32'(err_valid), 32'(v && chk));
        if (err_valid && sb_q.size() > 0) begin
            exp_f = sb_q.pop_front();
            check("err_flags", 32'(err_flags), 32'(exp_f));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_locked"},   32'(locked),    32'd0);
        check({tag, "_err_valid"}, 32'(err_valid), 32'd0);
        check({tag, "_err_flags"}, 32'(err_flags), 32'd0);
        check({tag, "_bit_cnt"},  bit_cnt,        32'd0);
        check({tag, "_err_cnt"},  err_cnt,        32'd0);
        check({tag, "_loss_cnt"}, 32'(loss_cnt),  32'd0);
        check({tag, "_bit_cnt8"}, 32'(bit_cnt8),  32'd0);
        check({tag, "_locked8"},  32'(locked8),   32'd0);
    endtask

    initial begin
        tbl[0] = '{v:1'b0, c:1'b1, flip:4'h0, chk:1'b0, exp_lk:1'b1, exp_bit:0,  exp_err:0, exp_loss:0};
        tbl[1] = '{v:1'b1, c:1'b0, flip:4'h4, chk:1'b1, exp_lk:1'b1, exp_bit:4,  exp_err:1, exp_loss:0};
        tbl[2] = '{v:1'b1, c:1'b0, flip:4'h0, chk:1'b1, exp_lk:1'b1, exp_bit:8,  exp_err:1, exp_loss:0};
        tbl[3] = '{v:1'b1, c:1'b0, flip:4'h0, chk:1'b1, exp_lk:1'b1, exp_bit:12, exp_err:1, exp_loss:0};
        tbl[4] = '{v:1'b0, c:1'b0, flip:4'h0, chk:1'b0, exp_lk:1'b1, exp_bit:12, exp_err:1, exp_loss:0};
        tbl[5] = '{v:1'b0, c:1'b1, flip:4'h0, chk:1'b0, exp_lk:1'b1, exp_bit:0,  exp_err:0, exp_loss:0};
        tbl[6] = '{v:1'b1, c:1'b0, flip:4'hF, chk:1'b1, exp_lk:1'b1, exp_bit:4,  exp_err:4, exp_loss:0};
        tbl[7] = '{v:1'b1, c:1'b0, flip:4'hF, chk:1'b1, exp_lk:1'b0, exp_bit:8,  exp_err:8, exp_loss:1};
        tbl[8] = '{v:1'b1, c:1'b0, flip:4'h0, chk:1'b0, exp_lk:1'b0, exp_bit:8,  exp_err:8, exp_loss:1};

        gen      = 23'h7FFFFF;
        rst_n    = 1'b0;
        clr      = 1'b0;
        valid_in = 1'b0;
        bits_in  = 4'h0;
        send(1'b0, 4'h0, 1'b0, 1'b0);
        send(1'b0, 4'h0, 1'b0, 1'b0);
        check_reset_vals("rst");
        rst_n = 1'b1;

        // Clean acquisition: lock after exactly 22 symbols
        for (int i = 0; i < 21; i++) send(1'b1, 4'h0, 1'b0, 1'b0);
        check("lock_21", 32'(locked), 32'd0);
        send(1'b1, 4'h0, 1'b0, 1'b0);
        check("lock_22", 32'(locked), 32'd1);

        for (int i = 0; i < 100; i++) send(1'b1, 4'h0, 1'b0, 1'b1);
        check("clean_bit_cnt", bit_cnt, 32'd400);
        check("clean_err_cnt", err_cnt, 32'd0);
        check("sat_bit_cnt8",  32'(bit_cnt8), 32'd255);
        check("sat_err_cnt8",  32'(err_cnt8), 32'd0);

        // Single error, no multiplication, then loss of lock
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].v, tbl[i].flip, tbl[i].c, tbl[i].chk);
            check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].exp_lk));
            check($sformatf("tbl%0d_bit_cnt", i), bit_cnt, tbl[i].exp_bit);
            check($sformatf("tbl%0d_err_cnt", i), err_cnt, tbl[i].exp_err);
            check($sformatf("tbl%0d_loss_cnt", i), 32'(loss_cnt), tbl[i].exp_loss);
        end

        // Reacquire: tbl[8] was the first of 22 symbols
        for (int i = 0; i < 20; i++) send(1'b1, 4'h0, 1'b0, 1'b0);
        check("reacq_21", 32'(locked), 32'd0);
        send(1'b1, 4'h0, 1'b0, 1'b0);
        check("reacq_22", 32'(locked), 32'd1);
        check("reacq_bit_cnt", bit_cnt, 32'd8);

        // Reset while locked
        rst_n = 1'b0;
        send(1'b0, 4'h0, 1'b0, 1'b0);
        check_reset_vals("midrst");
        rst_n = 1'b1;

        // Error in VERIFY at symbol 10 restarts seeding
        for (int i = 0; i < 9; i++) send(1'b1, 4'h0, 1'b0, 1'b0);
        send(1'b1, 4'h2, 1'b0, 1'b0);
        check("verr_sym10", 32'(locked), 32'd0);
        for (int i = 0; i < 21; i++) send(1'b1, 4'h0, 1'b0, 1'b0);
        check("verr_21", 32'(locked), 32'd0);
        send(1'b1, 4'h0, 1'b0, 1'b0);
        check("verr_22", 32'(locked), 32'd1);
        check("verr_err_cnt", err_cnt, 32'd0);

        // Random bubbles give the same counts as a gap-free stream
        send(1'b0, 4'h0, 1'b1, 1'b0);
        check("bub_clr_bit", bit_cnt, 32'd0);
        for (int i = 0; i < 50; i++) begin
            int unsigned gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < int'(gaps); g++) send(1'b0, 4'h0, 1'b0, 1'b0);
            send(1'b1, 4'h0, 1'b0, 1'b1);
        end
        check("bub_bit_cnt",  bit_cnt, 32'd200);
        check("bub_err_cnt",  err_cnt, 32'd0);
        check("bub_bit_cnt8", 32'(bit_cnt8), 32'd200);
        check("bub_locked",   32'(locked), 32'd1);

        // clr coincident with an errored valid symbol discards it
        send(1'b1, 4'h1, 1'b1, 1'b1);
        check("clrerr_bit_cnt", bit_cnt, 32'd0);
        check("clrerr_err_cnt", err_cnt, 32'd0);
        check("clrerr_locked",  32'(locked), 32'd1);
        send(1'b1, 4'h0, 1'b0, 1'b1);
        send(1'b1, 4'h0, 1'b0, 1'b1);
        check("post_clr_bit_cnt", bit_cnt, 32'd8);
        check("post_clr_err_cnt", err_cnt, 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
